uart_rx_mem_loader: RTL
=======================

# uart_rx_mem_loader

Downstream consumer of `uart_receiver`. Takes the received byte stream (`dataOut` / `new_byte_indicate`) and parses a length-prefixed load frame. Packs bytes into memory words and issues sequential single-cycle writes from address 0, so a host PC can fill instruction/data memory of the multicore processor before execution starts. Sits between the UART receive path and the memory write port; controlled by the top-level processor controller through `start`/`busy`/`done`.

## Interface

Parameters:
- `DATA_WIDTH`, 8: UART byte width; must match `uart_receiver`.
- `WORD_BYTES`, 2: bytes per memory word; valid range 1..4.
- `ADDR_WIDTH`, 12: memory address width; capacity is `2**ADDR_WIDTH` words.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. Synchronous and active-high; the clock is the single clock `clk`.
- `start`, input, 1: one-cycle pulse that arms the loader. Honoured only in IDLE.
- `dataIn`, input, `DATA_WIDTH`: received byte, connected to `uart_receiver.dataOut`.
- `new_byte_indicate`, input, 1: one-cycle strobe marking `dataIn` valid.
- `mem_wr_en`, output, 1: one-cycle memory write strobe.
- `mem_addr`, output, `ADDR_WIDTH`: write address.
- `mem_wr_data`, output, `WORD_BYTES*DATA_WIDTH`: write data.
- `busy`, output, 1: high from the accepted `start` until the return to IDLE.
- `done`, output, 1: one-cycle pulse when the frame completes successfully.
- `error`, output, 1: one-cycle pulse when the length is illegal.

## Operation

- Frame format:
  - byte 0: LEN[7:0]
  - byte 1: LEN[15:8]
  - then LEN words, each `WORD_BYTES` bytes, most-significant byte first.
- States:
  - IDLE: `start` → LEN_LO. Strobes in IDLE are ignored.
  - LEN_LO: strobe → latch low byte → LEN_HI.
  - LEN_HI: strobe → latch high byte, then decide:
    - LEN == 0 → FINISH.
    - LEN > `2**ADDR_WIDTH` → FAIL.
    - otherwise → DATA.
  - DATA: on each strobe, shift the byte into the word assembly register and increment the byte counter.
    - On the last byte of a word, register the word and pulse `mem_wr_en`.
    - After word LEN−1 is written → FINISH.
  - FINISH: `done`=1 for one cycle → IDLE.
  - FAIL: `error`=1 for one cycle → IDLE.
- Address counter:
  - Cleared on an accepted `start`.
  - Increments after each write; never wraps, because LEN is bounded by capacity.
- Word counter: 17 bits wide so that LEN = 65535 compares correctly against capacity.
- `start` while not IDLE: ignored.
- Reset mid-frame: return to IDLE; discard the partial word and counters; no write is issued.

## Timing

- Reset values: `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `busy`=0, `done`=0, `error`=0; state IDLE.
- `busy` rises the cycle after `start` and falls the cycle after `done`/`error`.
- `mem_wr_en` is asserted exactly one cycle after the strobe carrying a word's last byte.
  - `mem_addr` and `mem_wr_data` are valid in that same cycle.
  - `mem_addr` and `mem_wr_data` hold their values until the next write.
- `done` occurs one cycle after the final `mem_wr_en`. For LEN=0, `done` occurs one cycle after the LEN_HI strobe.
- `error` occurs one cycle after the LEN_HI strobe.
- Back-to-back strobes on consecutive cycles must be accepted without loss. The block imposes no minimum byte spacing, although UART spacing is thousands of cycles.

## Structure

- Shared package `uart_pkg`:
  - state enum `loader_state_t`.
  - `LEN_BYTES = 2`.
  - the frame byte-order definition.
- One natural sub-module: `byte_packer`.
  - Shift register plus byte counter.
  - Emits `word_valid` and `word` after `WORD_BYTES` strobes.
  - Has a `clear` input driven by `rst` and by accepted `start`.
- The top level holds only the FSM and the address/word counters.

## Test plan

All scenarios use `WORD_BYTES`=2, `ADDR_WIDTH`=4.

1. Basic load. `start`, then bytes 02 00 AB CD 12 34.
   - Writes addr 0 = 0xABCD, then addr 1 = 0x1234.
   - `done` one cycle after the second write; `busy` then drops.
2. LEN=0. Bytes 00 00.
   - No `mem_wr_en`; `done` one cycle after the second strobe.
3. Oversize. Bytes 11 00 (LEN=17 > 16).
   - `error` pulse and no writes.
   - Subsequent bytes ignored until the next `start`.
4. Full capacity. LEN=16 with 32 data bytes.
   - Addresses 0..15 written in order; last address 15; `done`.
5. Ignored inputs.
   - Bytes before `start` are ignored.
   - A second `start` during DATA is ignored; the frame completes normally.
6. Reset mid-word. Assert `rst` after byte AB of word 0.
   - All outputs return to 0 and no write occurs.
   - A new frame 01 00 55 66 writes addr 0 = 0x5566.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART load path: loader FSM states and load-frame layout.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_FINISH,
        ST_FAIL
    } loader_state_t;

    localparam int LEN_BYTES  = 2;
    localparam int LEN_BYTE_W = 8;
    localparam int LEN_W      = LEN_BYTES * LEN_BYTE_W;
    // One bit wider than LEN so that LEN=65535 compares cleanly against capacity.
    localparam int WORD_CNT_W = LEN_W + 1;

    // Frame byte order: the length arrives low byte first; payload words arrive MSB first.
    function automatic logic [LEN_W-1:0] frame_len(input logic [LEN_BYTE_W-1:0] hi_byte,
                                                   input logic [LEN_BYTE_W-1:0] lo_byte);
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Shifts received bytes MSB-first into a memory word and flags the byte that completes it.
module byte_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 2
) (
    input  logic                             clk,
    input  logic                             clear,
    input  logic                             byte_valid,
    input  logic [DATA_WIDTH-1:0]            byte_in,
    output logic                             word_valid,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] word
);

    localparam int WORD_W = WORD_BYTES * DATA_WIDTH;

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [2:0]        cnt_q, cnt_d;

    // The completed word is presented combinationally with the byte that finishes it.
    always_comb begin
        word = shift_q << DATA_WIDTH;
        word[DATA_WIDTH-1:0] = byte_in;
        word_valid = byte_valid && (cnt_q == 3'(WORD_BYTES - 1));
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (byte_valid) begin
            shift_d = word;
            cnt_d   = word_valid ? 3'd0 : cnt_q + 3'd1;
        end
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_mem_loader.sv
// Parses a length-prefixed frame from the UART byte stream and writes packed words
// sequentially from address 0.
module uart_rx_mem_loader
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 2,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [DATA_WIDTH-1:0]            dataIn,
    input  logic                             new_byte_indicate,
    output logic                             mem_wr_en,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] mem_wr_data,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int WORD_W = WORD_BYTES * DATA_WIDTH;
    localparam logic [WORD_CNT_W-1:0] CAPACITY = WORD_CNT_W'(1) << ADDR_WIDTH;
    localparam logic [WORD_CNT_W-1:0] CNT_ONE  = WORD_CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    loader_state_t           state_q, state_d;
    logic [WORD_CNT_W-1:0]   len_q, len_d;
    logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_cnt_q, addr_cnt_d;
    logic                    mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]       mem_wr_data_q, mem_wr_data_d;

    logic                    start_accept;
    logic                    packer_valid;
    logic                    word_valid;
    logic [WORD_W-1:0]       word;

    assign start_accept = start && (state_q == ST_IDLE);
    // Once the last word is written, further strobes must not start a new partial word.
    assign packer_valid = new_byte_indicate && (state_q == ST_DATA) && (word_cnt_q != len_q);

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_BYTES (WORD_BYTES)
    ) u_byte_packer (
        .clk        (clk),
        .clear      (rst || start_accept),
        .byte_valid (packer_valid),
        .byte_in    (dataIn),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        word_cnt_d    = word_cnt_q;
        addr_cnt_d    = addr_cnt_q;
        mem_wr_en_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    len_d      = '0;
                    word_cnt_d = '0;
                    addr_cnt_d = '0;
                    state_d    = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (new_byte_indicate) begin
                    len_d[LEN_BYTE_W-1:0] = dataIn[LEN_BYTE_W-1:0];
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (new_byte_indicate) begin
                    len_d = WORD_CNT_W'(frame_len(dataIn[LEN_BYTE_W-1:0], len_q[LEN_BYTE_W-1:0]));
                    if (len_d == '0)
                        state_d = ST_FINISH;
                    else if (len_d > CAPACITY)
                        state_d = ST_FAIL;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_cnt_q == len_q) begin
                    state_d = ST_FINISH;
                end else if (word_valid) begin
                    mem_wr_en_d   = 1'b1;
                    mem_addr_d    = addr_cnt_q;
                    mem_wr_data_d = word;
                    addr_cnt_d    = addr_cnt_q + ADDR_ONE;
                    word_cnt_d    = word_cnt_q + CNT_ONE;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_FAIL:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            word_cnt_q    <= '0;
            addr_cnt_q    <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            word_cnt_q    <= word_cnt_d;
            addr_cnt_q    <= addr_cnt_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign mem_wr_en   = mem_wr_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign error       = (state_q == ST_FAIL);

endmodule
